sub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one magnitude subtractor between two requesters. Each requester presents an operand pair and a request. The block grants one requester, latches its operands and computes the magnitude of the difference with a sign flag. It then returns the registered result with a one-cycle done pulse to the granted requester. It sits between the operand sources and the subtraction datapath, so only one copy of the subtractor is needed.

---
 rtl/sub_arbiter.sv | 114 +++++++++++
 tb/tb_sub_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one magnitude subtractor between two requesters.
// Each operation takes three cycles: grant/capture, subtract, done.
module sub_arbiter #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] result,
    output logic              neg,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                owner_q, owner_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                neg_q, neg_d;

    logic                any_req;
    logic                win;
    logic [DATA_W:0]     sub_res;

    // Returns {sign, |a - b|}; the sign is the borrow of a one-bit-wider signed subtract.
    function automatic logic [DATA_W:0] mag_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic signed [DATA_W:0] diff;
        logic signed [DATA_W:0] absd;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        absd = diff[DATA_W] ? -diff : diff;
        return {diff[DATA_W], absd[DATA_W-1:0]};
    endfunction

    assign any_req = req0 | req1;
    // Requester 1 wins when alone, or when both ask and priority points at it.
    assign win     = req1 & (~req0 | prio_q);
    assign sub_res = mag_sub(op_a_q, op_b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = CALC;
                    owner_d = win;
                    prio_d  = ~win;
                    op_a_d  = win ? a1 : a0;
                    op_b_d  = win ? b1 : b0;
                end
            end
            CALC: begin
                state_d  = DONE;
                neg_d    = sub_res[DATA_W];
                result_d = sub_res[DATA_W-1:0];
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt0   = (state_q == CALC) & ~owner_q;
        gnt1   = (state_q == CALC) &  owner_q;
        done0  = (state_q == DONE) & ~owner_q;
        done1  = (state_q == DONE) &  owner_q;
        busy   = (state_q != IDLE);
        result = result_q;
        neg    = neg_q;
    end

endmodule

// File: tb/tb_sub_arbiter.sv
// Directed bench for sub_arbiter: expected results are queued when a request is
// driven and checked when the matching done pulse appears.
module tb_sub_arbiter;

    localparam int DATA_W = 4;

    typedef struct packed {
        logic              id;
        logic [DATA_W-1:0] r;
        logic              n;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              req0, req1;
    logic [DATA_W-1:0] a0, b0, a1, b1;
    logic              gnt0, gnt1, done0, done1, neg, busy;
    logic [DATA_W-1:0] result;

    int   checks;
    int   passed;
    exp_t sb[$];
    logic gq[$];

    sub_arbiter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .neg(neg), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic id, input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b);
        exp_t e;
        e.id = id;
        if (a >= b) begin
            e.r = a - b;
            e.n = 1'b0;
        end else begin
            e.r = b - a;
            e.n = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot_pulses", int'($countones({gnt0, gnt1, done0, done1}) <= 1), 1);
    endtask

    task automatic wait_gnt(input logic id);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (gnt0 | gnt1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("gnt_seen", int'(seen), 1);
        chk("gnt_id", int'(gnt1), int'(id));
        chk("busy_in_calc", int'(busy), 1);
    endtask

    task automatic expect_done(input logic id);
        exp_t e;
        tick();
        chk(id ? "done1" : "done0", int'(id ? done1 : done0), 1);
        chk("busy_in_done", int'(busy), 1);
        chk("sb_nonempty", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_owner", int'(id), int'(e.id));
            chk("result", int'(result), int'(e.r));
            chk("neg", int'(neg), int'(e.n));
        end
    endtask

    task automatic run_op(input logic id, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b);
        if (id) begin
            req1 = 1'b1; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b;
        end
        sb.push_back(model(id, a, b));
        wait_gnt(id);
        req0 = 1'b0;
        req1 = 1'b0;
        expect_done(id);
        tick();
        chk("busy_back_idle", int'(busy), 0);
    endtask

    initial begin
        exp_t e;
        logic g;
        int   ndone;
        checks = 0;
        passed = 0;
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 4'd9; b0 = 4'd3; a1 = 4'd3; b1 = 4'd9;

        // Reset held with both requests active
        repeat (3) begin
            @(posedge clk);
        end
        #1;
        chk("rst_gnt0", int'(gnt0), 0);
        chk("rst_gnt1", int'(gnt1), 0);
        chk("rst_done0", int'(done0), 0);
        chk("rst_done1", int'(done1), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_neg", int'(neg), 0);
        rst_n = 1'b1;

        // First grant after reset favours requester 0
        sb.push_back(model(1'b0, 4'd9, 4'd3));
        wait_gnt(1'b0);
        req0 = 1'b0;
        req1 = 1'b0;
        expect_done(1'b0);
        tick();
        chk("busy_back_idle", int'(busy), 0);

        run_op(1'b1, 4'd3, 4'd9);
        run_op(1'b0, 4'd0, 4'd15);
        run_op(1'b1, 4'd15, 4'd0);
        run_op(1'b0, 4'd7, 4'd7);
        run_op(1'b1, 4'd12, 4'd12);

        // Contention: both requesters active for 12 cycles
        a0 = 4'd14; b0 = 4'd5; a1 = 4'd2; b1 = 4'd11;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(model(1'b0, a0, b0));
            gq.push_back(1'b0);
            sb.push_back(model(1'b1, a1, b1));
            gq.push_back(1'b1);
        end
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (gnt0 | gnt1) begin
                chk("cont_gq_nonempty", int'(gq.size() > 0), 1);
                if (gq.size() > 0) begin
                    g = gq.pop_front();
                    chk("cont_gnt_order", int'(gnt1), int'(g));
                end
            end
            if (done0 | done1) begin
                ndone++;
                chk("cont_sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("cont_done_owner", int'(done1), int'(e.id));
                    chk("cont_result", int'(result), int'(e.r));
                    chk("cont_neg", int'(neg), int'(e.n));
                end
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk("cont_grants_all", int'(gq.size()), 0);
        chk("cont_dones", ndone, 4);
        tick();
        tick();
        chk("cont_idle", int'(busy), 0);
        chk("cont_last_result", int'(result), 9);

        // Abort: reset pulse while requester 0 is in CALC
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd2;
        wait_gnt(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_neg", int'(neg), 0);
        chk("abort_done0", int'(done0), 0);
        tick();
        chk("abort_no_done", int'(done0 | done1), 0);
        rst_n = 1'b1;
        sb.push_back(model(1'b0, 4'd5, 4'd2));
        wait_gnt(1'b0);
        req0 = 1'b0;
        expect_done(1'b0);
        tick();
        chk("busy_back_idle", int'(busy), 0);
        chk("sb_drained", int'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
